// File: rtl/sccpu_pkg.sv
// Shared types and constants for the single-cycle CPU data-memory side.
package sccpu_pkg;

   localparam int unsigned SB_DEPTH_DEFAULT = 4;
   localparam int unsigned WORD_LSB         = 2;
   localparam int unsigned SB_AW            = 32;
   localparam int unsigned SB_DW            = 32;

   typedef struct packed {
      logic             valid;
      logic [SB_AW-1:0] addr;
      logic [SB_DW-1:0] data;
   } sb_entry_t;

endpackage

// File: rtl/sccpu_sb_fwd.sv
// Store-to-load forwarding: returns the youngest valid entry matching the load word,
// falling back to backing-memory read data.
module sccpu_sb_fwd
   import sccpu_pkg::*;
#(
   parameter int unsigned DEPTH = SB_DEPTH_DEFAULT,
   parameter int unsigned AW    = SB_AW,
   parameter int unsigned DW    = SB_DW
) (
   input  sb_entry_t                  entries [DEPTH],
   input  logic [$clog2(DEPTH)-1:0]   wr_ptr,
   input  logic [AW-1:0]              cpu_addr,
   input  logic [DW-1:0]              ram_rdata,
   output logic [DW-1:0]              cpu_rdata
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic unused_lsbs;

   // Walk from oldest slot (wr_ptr - DEPTH) to youngest (wr_ptr - 1); later hits win.
   always_comb begin
      logic [PW-1:0] idx;
      idx         = '0;
      cpu_rdata   = ram_rdata;
      unused_lsbs = ^cpu_addr[WORD_LSB-1:0];
      for (int k = int'(DEPTH); k > 0; k--) begin
         idx = wr_ptr - PW'(k);
         if (entries[idx].valid &&
             entries[idx].addr[AW-1:WORD_LSB] == cpu_addr[AW-1:WORD_LSB]) begin
            cpu_rdata = entries[idx].data;
         end
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
         unused_lsbs = unused_lsbs ^ (^entries[i].addr[WORD_LSB-1:0]);
      end
   end

endmodule

// File: rtl/sccpu_store_buffer.sv
// In-order store buffer between the single-cycle core and a slower backing memory,
// with zero-latency store-to-load forwarding.
module sccpu_store_buffer
   import sccpu_pkg::*;
#(
   parameter int unsigned DEPTH = SB_DEPTH_DEFAULT,
   parameter int unsigned AW    = SB_AW,
   parameter int unsigned DW    = SB_DW
) (
   input  logic                     clk,
   input  logic                     clrn,
   input  logic                     cpu_wmem,
   input  logic [AW-1:0]            cpu_addr,
   input  logic [DW-1:0]            cpu_wdata,
   output logic [DW-1:0]            cpu_rdata,
   output logic                     cpu_stall,
   output logic [AW-1:0]            ram_raddr,
   input  logic [DW-1:0]            ram_rdata,
   output logic                     bus_wvalid,
   output logic [AW-1:0]            bus_waddr,
   output logic [DW-1:0]            bus_wdata,
   input  logic                     bus_wready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   sb_entry_t     entries_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW:0]   count_q;
   logic          full, enq, deq;

   always_comb begin
      full       = (count_q == FULL_CNT);
      empty      = (count_q == '0);
      cpu_stall  = cpu_wmem & full;
      // A full buffer refuses the store even if the head drains this cycle.
      enq        = cpu_wmem & ~full;
      bus_wvalid = ~empty;
      deq        = bus_wvalid & bus_wready;
      bus_waddr  = entries_q[rd_ptr_q].addr;
      bus_wdata  = entries_q[rd_ptr_q].data;
      ram_raddr  = cpu_addr;
      count      = count_q;
   end

   always_ff @(posedge clk) begin
      if (!clrn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            entries_q[i].valid <= 1'b0;
         end
      end else begin
         if (deq) begin
            entries_q[rd_ptr_q].valid <= 1'b0;
            rd_ptr_q                  <= rd_ptr_q + 1'b1;
         end
         if (enq) begin
            entries_q[wr_ptr_q] <= '{valid: 1'b1, addr: cpu_addr, data: cpu_wdata};
            wr_ptr_q            <= wr_ptr_q + 1'b1;
         end
         unique case ({enq, deq})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   sccpu_sb_fwd #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_fwd (
      .entries   (entries_q),
      .wr_ptr    (wr_ptr_q),
      .cpu_addr  (cpu_addr),
      .ram_rdata (ram_rdata),
      .cpu_rdata (cpu_rdata)
   );

endmodule

// File: tb/tb_sccpu_store_buffer.sv
// Directed, table-driven bench for sccpu_store_buffer (DEPTH=4).
module tb_sccpu_store_buffer;

   logic        clk = 1'b0;
   logic        clrn;
   logic        cpu_wmem;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_stall;
   logic [31:0] ram_raddr, ram_rdata;
   logic        bus_wvalid, bus_wready;
   logic [31:0] bus_waddr, bus_wdata;
   logic [2:0]  count;
   logic        empty;

   int checks = 0;
   int errors = 0;
   logic [63:0] wlog[$];

   always #5 clk = ~clk;

   sccpu_store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
      .clk        (clk),
      .clrn       (clrn),
      .cpu_wmem   (cpu_wmem),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_stall  (cpu_stall),
      .ram_raddr  (ram_raddr),
      .ram_rdata  (ram_rdata),
      .bus_wvalid (bus_wvalid),
      .bus_waddr  (bus_waddr),
      .bus_wdata  (bus_wdata),
      .bus_wready (bus_wready),
      .count      (count),
      .empty      (empty)
   );

   // Record every accepted bus write.
   always @(posedge clk) begin
      if (clrn && bus_wvalid && bus_wready) wlog.push_back({bus_waddr, bus_wdata});
   end

   typedef struct {
      logic        wmem;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        wready;
      logic [31:0] ram;
      logic [31:0] e_rdata;
      logic        e_stall;
      logic        e_wvalid;
      logic [31:0] e_waddr;
      logic [31:0] e_wdata;
      logic [2:0]  e_count;
   } vec_t;

   vec_t vecs[26];

   function automatic vec_t mk(logic w, logic [31:0] a, logic [31:0] d, logic r,
                               logic [31:0] ram, logic [31:0] er, logic es, logic ev,
                               logic [31:0] ea, logic [31:0] ed, logic [2:0] ec);
      vec_t v;
      v = '{w, a, d, r, ram, er, es, ev, ea, ed, ec};
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic r, input logic [31:0] ram);
      cpu_wmem   = w;
      cpu_addr   = a;
      cpu_wdata  = d;
      bus_wready = r;
      ram_rdata  = ram;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = mk(0, 32'h100, 0, 0, 32'hDEAD0000, 32'hDEAD0000, 0, 0, 0, 0, 0);
      vecs[1]  = mk(1, 32'h100, 32'h11111111, 0, 32'hAAAA0001, 32'hAAAA0001, 0, 0, 0, 0, 0);
      vecs[2]  = mk(1, 32'h104, 32'h22222222, 0, 32'hAAAA0002, 32'hAAAA0002, 0, 1,
                    32'h100, 32'h11111111, 1);
      vecs[3]  = mk(1, 32'h100, 32'h33333333, 0, 32'hAAAA0003, 32'h11111111, 0, 1,
                    32'h100, 32'h11111111, 2);
      vecs[4]  = mk(0, 32'h100, 0, 0, 32'hAAAA0004, 32'h33333333, 0, 1,
                    32'h100, 32'h11111111, 3);
      vecs[5]  = mk(0, 32'h102, 0, 0, 32'hAAAA0005, 32'h33333333, 0, 1,
                    32'h100, 32'h11111111, 3);
      vecs[6]  = mk(0, 32'h104, 0, 0, 32'hAAAA0006, 32'h22222222, 0, 1,
                    32'h100, 32'h11111111, 3);
      vecs[7]  = mk(0, 32'h108, 0, 0, 32'hBEEF0008, 32'hBEEF0008, 0, 1,
                    32'h100, 32'h11111111, 3);
      vecs[8]  = mk(1, 32'h10C, 32'h44444444, 0, 0, 0, 0, 1, 32'h100, 32'h11111111, 3);
      vecs[9]  = mk(1, 32'h110, 32'h55555555, 0, 0, 0, 1, 1, 32'h100, 32'h11111111, 4);
      vecs[10] = mk(1, 32'h110, 32'h55555555, 0, 0, 0, 1, 1, 32'h100, 32'h11111111, 4);
      vecs[11] = mk(1, 32'h110, 32'h55555555, 1, 0, 0, 1, 1, 32'h100, 32'h11111111, 4);
      vecs[12] = mk(1, 32'h110, 32'h55555555, 0, 0, 0, 0, 1, 32'h104, 32'h22222222, 3);
      vecs[13] = mk(0, 32'h110, 0, 0, 0, 32'h55555555, 0, 1, 32'h104, 32'h22222222, 4);
      vecs[14] = mk(0, 32'h100, 0, 0, 0, 32'h33333333, 0, 1, 32'h104, 32'h22222222, 4);
      vecs[15] = mk(0, 32'h104, 0, 1, 0, 32'h22222222, 0, 1, 32'h104, 32'h22222222, 4);
      vecs[16] = mk(0, 32'h100, 0, 1, 0, 32'h33333333, 0, 1, 32'h100, 32'h33333333, 3);
      vecs[17] = mk(0, 32'h10C, 0, 1, 0, 32'h44444444, 0, 1, 32'h10C, 32'h44444444, 2);
      vecs[18] = mk(0, 32'h110, 0, 1, 0, 32'h55555555, 0, 1, 32'h110, 32'h55555555, 1);
      vecs[19] = mk(0, 32'h110, 0, 0, 32'h77, 32'h77, 0, 0, 0, 0, 0);
      vecs[20] = mk(1, 32'h10, 32'h1, 1, 0, 0, 0, 0, 0, 0, 0);
      vecs[21] = mk(1, 32'h14, 32'h2, 0, 0, 0, 0, 1, 32'h10, 32'h1, 1);
      vecs[22] = mk(1, 32'h18, 32'h3, 1, 0, 0, 0, 1, 32'h10, 32'h1, 2);
      vecs[23] = mk(0, 32'h18, 0, 1, 0, 32'h3, 0, 1, 32'h14, 32'h2, 2);
      vecs[24] = mk(0, 32'h14, 0, 1, 32'hABCD, 32'hABCD, 0, 1, 32'h18, 32'h3, 1);
      vecs[25] = mk(0, 32'h10, 0, 0, 32'h1234, 32'h1234, 0, 0, 0, 0, 0);

      // Reset and idle
      clrn = 1'b0;
      drive(0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_wvalid", 64'(bus_wvalid), 64'd0);
      chk("reset_empty", 64'(empty), 64'd1);
      chk("reset_count", 64'(count), 64'd0);
      chk("reset_stall", 64'(cpu_stall), 64'd0);
      clrn = 1'b1;

      // Forwarding, full/stall, drain order
      for (int i = 0; i < 26; i++) begin
         drive(vecs[i].wmem, vecs[i].addr, vecs[i].wdata, vecs[i].wready, vecs[i].ram);
         #2;
         chk($sformatf("v%0d_rdata", i), 64'(cpu_rdata), 64'(vecs[i].e_rdata));
         chk($sformatf("v%0d_raddr", i), 64'(ram_raddr), 64'(vecs[i].addr));
         chk($sformatf("v%0d_stall", i), 64'(cpu_stall), 64'(vecs[i].e_stall));
         chk($sformatf("v%0d_wvalid", i), 64'(bus_wvalid), 64'(vecs[i].e_wvalid));
         chk($sformatf("v%0d_count", i), 64'(count), 64'(vecs[i].e_count));
         chk($sformatf("v%0d_empty", i), 64'(empty), 64'(vecs[i].e_count == 3'd0));
         if (vecs[i].e_wvalid) begin
            chk($sformatf("v%0d_waddr", i), 64'(bus_waddr), 64'(vecs[i].e_waddr));
            chk($sformatf("v%0d_wdata", i), 64'(bus_wdata), 64'(vecs[i].e_wdata));
         end
         tick();
      end

      // Simultaneous enqueue/dequeue across pointer wrap
      wlog.delete();
      drive(1, 32'h200, 32'h100, 0, 0);
      tick();
      drive(1, 32'h204, 32'h101, 0, 0);
      tick();
      for (int i = 0; i < 8; i++) begin
         drive(1, 32'h208 + 32'(4 * i), 32'h102 + 32'(i), 1, 0);
         #1;
         chk($sformatf("sim%0d_count", i), 64'(count), 64'd2);
         chk($sformatf("sim%0d_stall", i), 64'(cpu_stall), 64'd0);
         chk($sformatf("sim%0d_head", i), 64'(bus_waddr), 64'(32'h200 + 32'(4 * i)));
         tick();
      end
      drive(0, 0, 0, 1, 0);
      repeat (2) tick();
      drive(0, 0, 0, 0, 0);
      #1;
      chk("sim_empty", 64'(empty), 64'd1);
      chk("sim_nwrites", 64'(wlog.size()), 64'd10);
      for (int i = 0; i < 10 && i < wlog.size(); i++) begin
         chk($sformatf("sim_write%0d", i), wlog[i],
             {32'h200 + 32'(4 * i), 32'h100 + 32'(i)});
      end

      // Mid-operation reset
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'h300 + 32'(4 * i), 32'h900 + 32'(i), 0, 0);
         tick();
      end
      chk("prerst_count", 64'(count), 64'd3);
      wlog.delete();
      drive(0, 0, 0, 0, 0);
      clrn = 1'b0;
      tick();
      clrn = 1'b1;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_wvalid", 64'(bus_wvalid), 64'd0);
      chk("rst_empty", 64'(empty), 64'd1);
      drive(0, 32'h300, 0, 1, 32'hCAFE0300);
      #1;
      chk("rst_load", 64'(cpu_rdata), 64'hCAFE0300);
      repeat (4) tick();
      chk("rst_nwrites", 64'(wlog.size()), 64'd0);
      chk("rst_wvalid_late", 64'(bus_wvalid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
